wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Registered write-back stage for the MIPS pipeline; sits after the MEM stage and drives the register-file write port.
- Generalises the combinational write-back mux:
  - adds the MEM/WB pipeline register with stall/flush;
  - adds load-data byte/halfword extraction with sign/zero extension;
  - adds misaligned-load detection;
  - suppresses writes to $zero;
  - adds a committed-instruction counter for debug.

Parameters:
NB_REG, 32, data/register width
NB_REG_ADDR, 5, register address width
NB_LDTYPE, 3, load-type code width
NB_CNT, 32, retired-instruction counter width

Ports:
i_clock  in  1  system clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_valid  in  1  MEM stage presents a real instruction
i_stall  in  1  WB does not accept input this cycle
i_flush  in  1  kill instruction being captured
i_reg_dest  in  NB_REG_ADDR  destination register
i_reg_we  in  1  instruction writes a register
i_data_sel  in  2  00 load data, 10 ALU result, x1 link PC
i_alu_result  in  NB_REG  ALU result
i_mem_word  in  NB_REG  raw aligned memory word
i_load_type  in  NB_LDTYPE  000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU
i_byte_off  in  2  address bits [1:0] of the load
i_pc  in  NB_REG  link value, already adjusted upstream
o_wb_data  out  NB_REG  register write data
o_reg_dest  out  NB_REG_ADDR  register write address
o_reg_we  out  1  register write enable
o_valid  out  1  WB register holds a committed instruction
o_misaligned  out  1  one-cycle pulse: committed load was misaligned
o_retired  out  NB_CNT  committed-instruction count

Behaviour:
- Clock and reset: single clock i_clock. Reset is asynchronous and active-low on i_reset_n.
- Reset values: all outputs 0, including o_retired.
- Latency: one cycle. Inputs sampled at a rising edge appear on outputs after that edge. No combinational input-to-output path.
- Capture priority, evaluated each edge:
  - i_flush=1: load a bubble. o_valid=0, o_reg_we=0, o_misaligned=0, o_wb_data=0, o_reg_dest=0. Flush wins over stall.
  - else i_stall=1: load a bubble. o_valid=0, o_reg_we=0, o_misaligned=0; o_wb_data and o_reg_dest hold their previous values. The upstream stage retains its instruction.
  - else i_valid=0: bubble, same as stall.
  - else: capture the instruction with o_valid=1.
- Data select:
  - 00: formatted load data.
  - 10: i_alu_result.
  - 01 or 11: i_pc.
- Load formatting (little-endian lanes):
  - Byte: i_mem_word[8*i_byte_off +: 8].
  - Half: i_mem_word[16*i_byte_off[1] +: 16].
  - LB/LH sign-extend to NB_REG; LBU/LHU zero-extend.
  - LW and undefined codes (010, 110, 111): the full word.
- Misalignment, evaluated only when i_data_sel=00:
  - LH/LHU with i_byte_off[0]=1, or LW/undefined with i_byte_off!=0.
  - On capture: o_misaligned=1 for one cycle, o_reg_we=0, o_valid=1. o_wb_data takes the unformatted i_mem_word.
- Write enable: o_reg_we = i_reg_we && (i_reg_dest!=0) && !misaligned. A write to $zero is dropped, but the instruction still counts as committed.
- Retired counter:
  - Increments by 1 on each edge where a non-bubble is captured (the edge that sets o_valid=1).
  - Wraps from 2^NB_CNT-1 to 0.
  - Cleared only by reset.
- Reset mid-operation: all registers clear immediately, without waiting for a clock edge. The first edge after deassertion captures normally.

Decomposition:
- Shared package holds:
  - data-select codes: SEL_MEM=2'b00, SEL_ALU=2'b10, link pattern 2'b?1;
  - load-type codes: LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU;
  - the $zero address constant.
- Sub-module load_formatter: purely combinational.
  - Inputs: i_mem_word, i_load_type, i_byte_off.
  - Outputs: formatted data and misaligned flag.
- The MEM/WB register, select mux and counter stay in wb_stage.

Test Plan:
- ALU write: sel=10, alu=0x0000_1234, dest=5, we=1, valid=1 -> next cycle o_wb_data=0x1234, o_reg_dest=5, o_reg_we=1, o_retired=1.
- Loads, mem_word=0x80FF_7F01:
  - LB off=3 -> 0xFFFF_FF80.
  - LBU off=3 -> 0x0000_0080.
  - LH off=2 -> 0xFFFF_80FF.
  - LHU off=0 -> 0x0000_7F01.
  - LW off=0 -> 0x80FF_7F01.
- Misaligned: LW off=1, we=1 -> o_misaligned=1 for exactly one cycle, o_reg_we=0, o_valid=1, o_retired increments. Same for LH off=3.
- $zero and link:
  - dest=0, we=1, sel=10 -> o_reg_we=0, o_valid=1.
  - sel=01 and sel=11 with pc=0x0040_0008 -> o_wb_data=0x0040_0008.
- Stall, flush, reset:
  - stall=1 with a valid input -> o_reg_we=0, o_valid=0, data/dest held, counter unchanged.
  - stall=1 and flush=1 -> data=0.
  - i_reset_n low mid-stream -> all outputs 0 with no clock edge.
- Wrap: NB_CNT=4, 17 consecutive valid ALU instructions -> o_retired reaches 15, then 0, then 1.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared codes for the MIPS write-back stage: data-select, load-type and
// the hard-wired zero register address.
package wb_stage_pkg;

    localparam logic [1:0] SEL_MEM = 2'b00;
    localparam logic [1:0] SEL_ALU = 2'b10;

    typedef enum logic [2:0] {
        LT_LB  = 3'b000,
        LT_LH  = 3'b001,
        LT_LW  = 3'b011,
        LT_LBU = 3'b100,
        LT_LHU = 3'b101
    } load_type_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Any select code with bit 0 set picks the link PC.
    function automatic logic is_link_sel(input logic [1:0] sel);
        return sel[0];
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB bus: MEM-side request fields plus the register-file write port
// and debug outputs produced by the WB stage.
interface wb_stage_if #(
    parameter int NB_REG      = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int NB_LDTYPE   = 3,
    parameter int NB_CNT      = 32
);
    logic                   i_valid;
    logic                   i_stall;
    logic                   i_flush;
    logic [NB_REG_ADDR-1:0] i_reg_dest;
    logic                   i_reg_we;
    logic [1:0]             i_data_sel;
    logic [NB_REG-1:0]      i_alu_result;
    logic [NB_REG-1:0]      i_mem_word;
    logic [NB_LDTYPE-1:0]   i_load_type;
    logic [1:0]             i_byte_off;
    logic [NB_REG-1:0]      i_pc;

    logic [NB_REG-1:0]      o_wb_data;
    logic [NB_REG_ADDR-1:0] o_reg_dest;
    logic                   o_reg_we;
    logic                   o_valid;
    logic                   o_misaligned;
    logic [NB_CNT-1:0]      o_retired;

    modport master (
        output i_valid, i_stall, i_flush, i_reg_dest, i_reg_we, i_data_sel,
               i_alu_result, i_mem_word, i_load_type, i_byte_off, i_pc,
        input  o_wb_data, o_reg_dest, o_reg_we, o_valid, o_misaligned, o_retired
    );

    modport slave (
        input  i_valid, i_stall, i_flush, i_reg_dest, i_reg_we, i_data_sel,
               i_alu_result, i_mem_word, i_load_type, i_byte_off, i_pc,
        output o_wb_data, o_reg_dest, o_reg_we, o_valid, o_misaligned, o_retired
    );
endinterface

// File: rtl/wb_stage_load_formatter.sv
// Combinational load-data extraction (little-endian lanes) with sign/zero
// extension and alignment check for the addressed access size.
module load_formatter
    import wb_stage_pkg::*;
#(
    parameter int NB_REG    = 32,
    parameter int NB_LDTYPE = 3
) (
    input  logic [NB_REG-1:0]    i_mem_word,
    input  logic [NB_LDTYPE-1:0] i_load_type,
    input  logic [1:0]           i_byte_off,
    output logic [NB_REG-1:0]    o_data,
    output logic                 o_misaligned
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_mem_word[{i_byte_off, 3'b000} +: 8];
    assign w_half = i_mem_word[{i_byte_off[1], 4'b0000} +: 16];

    always_comb begin
        o_data       = i_mem_word;
        o_misaligned = 1'b0;
        case (i_load_type)
            NB_LDTYPE'(LT_LB):  o_data = {{(NB_REG-8){w_byte[7]}}, w_byte};
            NB_LDTYPE'(LT_LBU): o_data = {{(NB_REG-8){1'b0}}, w_byte};
            NB_LDTYPE'(LT_LH): begin
                o_data       = {{(NB_REG-16){w_half[15]}}, w_half};
                o_misaligned = i_byte_off[0];
            end
            NB_LDTYPE'(LT_LHU): begin
                o_data       = {{(NB_REG-16){1'b0}}, w_half};
                o_misaligned = i_byte_off[0];
            end
            // LW and the undefined codes all behave as a full-word load.
            default: o_misaligned = (i_byte_off != 2'b00);
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with stall/flush, write-back select mux,
// $zero write suppression and a committed-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int NB_REG      = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int NB_LDTYPE   = 3,
    parameter int NB_CNT      = 32
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    wb_stage_if.slave  bus
);
    logic [NB_REG-1:0]      w_fmt_data;
    logic                   w_fmt_mis;
    logic                   w_misaligned;
    logic                   w_capture;
    logic [NB_REG-1:0]      w_wb_data;
    logic                   w_reg_we;

    logic [NB_REG-1:0]      r_wb_data;
    logic [NB_REG_ADDR-1:0] r_reg_dest;
    logic                   r_reg_we;
    logic                   r_valid;
    logic                   r_misaligned;
    logic [NB_CNT-1:0]      r_retired;

    load_formatter #(
        .NB_REG    (NB_REG),
        .NB_LDTYPE (NB_LDTYPE)
    ) u_fmt (
        .i_mem_word   (bus.i_mem_word),
        .i_load_type  (bus.i_load_type),
        .i_byte_off   (bus.i_byte_off),
        .o_data       (w_fmt_data),
        .o_misaligned (w_fmt_mis)
    );

    // Alignment only matters when the load data is actually selected.
    assign w_misaligned = (bus.i_data_sel == SEL_MEM) && w_fmt_mis;
    assign w_capture    = !bus.i_flush && !bus.i_stall && bus.i_valid;
    assign w_reg_we     = bus.i_reg_we && !w_misaligned &&
                          (bus.i_reg_dest != NB_REG_ADDR'(REG_ZERO));

    always_comb begin
        w_wb_data = w_fmt_data;
        if (is_link_sel(bus.i_data_sel))
            w_wb_data = bus.i_pc;
        else if (bus.i_data_sel == SEL_ALU)
            w_wb_data = bus.i_alu_result;
        else if (w_misaligned)
            w_wb_data = bus.i_mem_word;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wb_data    <= '0;
            r_reg_dest   <= '0;
            r_reg_we     <= 1'b0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
            r_retired    <= '0;
        end else if (bus.i_flush) begin
            r_wb_data    <= '0;
            r_reg_dest   <= '0;
            r_reg_we     <= 1'b0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (!w_capture) begin
            // Stall or empty slot: bubble, but keep data/dest for debug visibility.
            r_reg_we     <= 1'b0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_wb_data    <= w_wb_data;
            r_reg_dest   <= bus.i_reg_dest;
            r_reg_we     <= w_reg_we;
            r_valid      <= 1'b1;
            r_misaligned <= w_misaligned;
            r_retired    <= r_retired + NB_CNT'(1);
        end
    end

    assign bus.o_wb_data    = r_wb_data;
    assign bus.o_reg_dest   = r_reg_dest;
    assign bus.o_reg_we     = r_reg_we;
    assign bus.o_valid      = r_valid;
    assign bus.o_misaligned = r_misaligned;
    assign bus.o_retired    = r_retired;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed cases then random traffic, each
// cycle's expected register state queued by the driver, popped by a monitor.
module tb_wb_stage;
    localparam int CNTW = 4;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        we;
        logic        vld;
        logic        mis;
        logic [CNTW-1:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t m;

    always #5 clk = ~clk;

    wb_stage_if #(.NB_CNT(CNTW)) bus ();

    wb_stage #(.NB_CNT(CNTW)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("wb_data",    bus.o_wb_data, e.data);
        chk("reg_dest",   32'(bus.o_reg_dest), 32'(e.dest));
        chk("reg_we",     32'(bus.o_reg_we), 32'(e.we));
        chk("valid",      32'(bus.o_valid), 32'(e.vld));
        chk("misaligned", 32'(bus.o_misaligned), 32'(e.mis));
        chk("retired",    32'(bus.o_retired), 32'(e.ret));
    endtask

    // Reference load behaviour written from the ISA rules, not from the RTL.
    task automatic ref_load(input logic [31:0] mem, input int lt, input int off,
                            output logic [31:0] data, output logic mis);
        logic [31:0] b, h;
        b = (mem >> (8 * off)) & 32'hFF;
        h = (mem >> (16 * (off / 2))) & 32'hFFFF;
        mis = 1'b0;
        data = mem;
        if (lt == 0)      data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
        else if (lt == 4) data = b;
        else if (lt == 1) begin data = (h >= 32768) ? h + 32'hFFFF_0000 : h; mis = (off % 2) != 0; end
        else if (lt == 5) begin data = h; mis = (off % 2) != 0; end
        else mis = (off != 0);
    endtask

    task automatic apply(input bit valid, input bit stall, input bit flush,
                         input int dest, input bit we, input int sel,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input int lt, input int off, input logic [31:0] pc);
        logic [31:0] ld;
        logic        mis;
        @(negedge clk);
        bus.i_valid      = valid;
        bus.i_stall      = stall;
        bus.i_flush      = flush;
        bus.i_reg_dest   = 5'(dest);
        bus.i_reg_we     = we;
        bus.i_data_sel   = 2'(sel);
        bus.i_alu_result = alu;
        bus.i_mem_word   = mem;
        bus.i_load_type  = 3'(lt);
        bus.i_byte_off   = 2'(off);
        bus.i_pc         = pc;
        if (flush) begin
            m.data = 0; m.dest = 0; m.we = 0; m.vld = 0; m.mis = 0;
        end else if (stall || !valid) begin
            m.we = 0; m.vld = 0; m.mis = 0;
        end else begin
            ref_load(mem, lt, off, ld, mis);
            if (sel != 0) mis = 1'b0;
            if (sel == 1 || sel == 3) m.data = pc;
            else if (sel == 2)        m.data = alu;
            else                      m.data = mis ? mem : ld;
            m.dest = 5'(dest);
            m.vld  = 1'b1;
            m.mis  = mis;
            m.we   = we && (dest != 0) && !mis;
            m.ret  = CNTW'((int'(m.ret) + 1) % (1 << CNTW));
        end
        q.push_back(m);
    endtask

    task automatic alu_op(input int dest, input logic [31:0] v);
        apply(1, 0, 0, dest, 1, 2, v, 32'h0, 3, 0, 32'h0);
    endtask

    task automatic load_op(input int lt, input int off);
        apply(1, 0, 0, 7, 1, 0, 32'h0, 32'h80FF_7F01, lt, off, 32'h0);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (q.size() != 0) chk_all(q.pop_front());
    end

    initial begin
        exp_t z;
        z = '{default: '0};
        m = z;
        bus.i_valid = 0; bus.i_stall = 0; bus.i_flush = 0; bus.i_reg_dest = 0;
        bus.i_reg_we = 0; bus.i_data_sel = 0; bus.i_alu_result = 0; bus.i_mem_word = 0;
        bus.i_load_type = 0; bus.i_byte_off = 0; bus.i_pc = 0;
        #3;
        chk_all(z);
        @(negedge clk);
        rst_n = 1'b1;

        alu_op(5, 32'h0000_1234);
        load_op(0, 3);
        load_op(4, 3);
        load_op(1, 2);
        load_op(5, 0);
        load_op(3, 0);
        load_op(3, 1);
        alu_op(6, 32'hDEAD_BEEF);
        load_op(1, 3);
        alu_op(0, 32'h1111_2222);
        apply(1, 0, 0, 31, 1, 1, 32'h0, 32'h0, 0, 0, 32'h0040_0008);
        apply(1, 0, 0, 30, 1, 3, 32'h0, 32'h0, 0, 0, 32'h0040_0008);
        apply(1, 1, 0, 9, 1, 2, 32'h5555_5555, 32'h0, 0, 0, 32'h0);
        apply(0, 0, 0, 9, 1, 2, 32'h6666_6666, 32'h0, 0, 0, 32'h0);
        apply(1, 1, 1, 9, 1, 2, 32'h7777_7777, 32'h0, 0, 0, 32'h0);
        alu_op(4, 32'h0000_00AA);

        // Asynchronous reset between edges, then release into an idle slot.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all(z);
        m = z;
        bus.i_valid = 0;
        q.push_back(m);
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(m);

        for (int i = 0; i < 17; i++) alu_op(i % 31 + 1, 32'(i * 3 + 1));

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 3);
            apply($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, $urandom_range(0, 19) < 2,
                  (r == 0) ? 0 : $urandom_range(1, 31), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), $urandom, $urandom,
                  $urandom_range(0, 7), $urandom_range(0, 3), $urandom);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
